// File: rtl/uart_frame_pkg.sv
// Shared constants, frame layout and FSM encoding for the UART frame scheduler.
package uart_frame_pkg;
  localparam logic [7:0] SOF        = 8'hA5;
  localparam logic [7:0] TYPE_TELE  = 8'h01;
  localparam logic [7:0] TYPE_ALERT = 8'h02;
  localparam int         FRAME_LEN  = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  // Byte 0 (SOF) is the first byte on the wire.
  typedef logic [FRAME_LEN-1:0][7:0] frame_t;
endpackage

// File: rtl/frame_period_timer.sv
// Free-running telemetry period counter; tick marks the wrap cycle while enabled.
module frame_period_timer #(
  parameter int unsigned CLKS_PER_PERIOD = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);
  localparam logic [25:0] LAST = 26'(CLKS_PER_PERIOD - 32'd1);

  logic [25:0] cnt_q;
  logic [25:0] cnt_d;
  logic        wrap_s;

  // Next count: hold at zero while disabled, wrap after LAST.
  always_comb begin
    wrap_s = (cnt_q == LAST);
    if (!enable) begin
      cnt_d = 26'd0;
    end else if (wrap_s) begin
      cnt_d = 26'd0;
    end else begin
      cnt_d = cnt_q + 26'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 26'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = enable & wrap_s;
endmodule

// File: rtl/uart_frame_scheduler.sv
// Builds 7-byte telemetry/alert frames and streams them to a UART transmitter
// over a valid/ready handshake; alerts win over periodic telemetry.
module uart_frame_scheduler
  import uart_frame_pkg::*;
#(
  parameter int unsigned CLKS_PER_PERIOD = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] moisture,
  input  logic [7:0] temperature,
  input  logic [7:0] light,
  input  logic [7:0] ai_decision,
  input  logic       alert_req,
  input  logic [7:0] alert_code,
  output logic       alert_ack,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic [7:0] frame_seq
);
  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic       tele_pending_q, tele_pending_d;
  logic       tx_valid_q, tx_valid_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       alert_ack_q, alert_ack_d;
  logic       busy_q, busy_d;
  logic [7:0] frame_seq_q, frame_seq_d;
  frame_t     frame_q, frame_d;

  logic       tick_s;
  logic       clear_tele_s;
  logic [2:0] idx_nxt_s;
  logic [7:0] next_byte_s;
  frame_t     tele_frame_s, alert_frame_s;

  function automatic logic [7:0] frame_chk(input logic [7:0] t, input logic [7:0] p0,
                                           input logic [7:0] p1, input logic [7:0] p2,
                                           input logic [7:0] p3);
    return t ^ p0 ^ p1 ^ p2 ^ p3;
  endfunction

  frame_period_timer #(.CLKS_PER_PERIOD(CLKS_PER_PERIOD)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .tick   (tick_s)
  );

  // Candidate frames assembled from live inputs; only sampled in LOAD.
  always_comb begin
    tele_frame_s  = {frame_chk(TYPE_TELE, moisture, temperature, light, ai_decision),
                     ai_decision, light, temperature, moisture, TYPE_TELE, SOF};
    alert_frame_s = {frame_chk(TYPE_ALERT, alert_code, frame_seq_q, 8'h00, 8'h00),
                     8'h00, 8'h00, frame_seq_q, alert_code, TYPE_ALERT, SOF};
    idx_nxt_s     = idx_q + 3'd1;
    case (idx_nxt_s)
      3'd0:    next_byte_s = frame_q[0];
      3'd1:    next_byte_s = frame_q[1];
      3'd2:    next_byte_s = frame_q[2];
      3'd3:    next_byte_s = frame_q[3];
      3'd4:    next_byte_s = frame_q[4];
      3'd5:    next_byte_s = frame_q[5];
      3'd6:    next_byte_s = frame_q[6];
      default: next_byte_s = 8'h00;
    endcase
  end

  // Sequencer next-state: IDLE -> LOAD (1 cycle snapshot) -> SEND (7 transfers).
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    alert_ack_d  = 1'b0;
    busy_d       = busy_q;
    frame_seq_d  = frame_seq_q;
    frame_d      = frame_q;
    clear_tele_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (alert_req || tele_pending_q) begin
          state_d = ST_LOAD;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (alert_req) begin
          frame_d     = alert_frame_s;
          alert_ack_d = 1'b1;
          state_d     = ST_SEND;
          idx_d       = 3'd0;
          tx_valid_d  = 1'b1;
          tx_data_d   = SOF;
        end else if (tele_pending_q) begin
          frame_d      = tele_frame_s;
          clear_tele_s = 1'b1;
          state_d      = ST_SEND;
          idx_d        = 3'd0;
          tx_valid_d   = 1'b1;
          tx_data_d    = SOF;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      ST_SEND: begin
        if (tx_valid_q && tx_ready) begin
          if (idx_q == 3'(FRAME_LEN - 1)) begin
            state_d     = ST_IDLE;
            idx_d       = 3'd0;
            tx_valid_d  = 1'b0;
            tx_data_d   = 8'h00;
            busy_d      = 1'b0;
            frame_seq_d = frame_seq_q + 8'd1;
          end else begin
            idx_d     = idx_nxt_s;
            tx_data_d = next_byte_s;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        idx_d      = 3'd0;
        tx_valid_d = 1'b0;
        tx_data_d  = 8'h00;
        busy_d     = 1'b0;
      end
    endcase
    // A fresh tick outranks the clear so it is never lost.
    if (tick_s) begin
      tele_pending_d = 1'b1;
    end else if (clear_tele_s) begin
      tele_pending_d = 1'b0;
    end else begin
      tele_pending_d = tele_pending_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      idx_q          <= 3'd0;
      tele_pending_q <= 1'b0;
      tx_valid_q     <= 1'b0;
      tx_data_q      <= 8'h00;
      alert_ack_q    <= 1'b0;
      busy_q         <= 1'b0;
      frame_seq_q    <= 8'h00;
      frame_q        <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      tele_pending_q <= tele_pending_d;
      tx_valid_q     <= tx_valid_d;
      tx_data_q      <= tx_data_d;
      alert_ack_q    <= alert_ack_d;
      busy_q         <= busy_d;
      frame_seq_q    <= frame_seq_d;
      frame_q        <= frame_d;
    end
  end

  assign alert_ack = alert_ack_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = busy_q;
  assign frame_seq = frame_seq_q;
endmodule

// File: doc/uart_frame_scheduler.md
UART_FRAME_SCHEDULER -- requirements
Module: uart_frame_scheduler

Interface
REQ-001 The block SHALL have parameter CLKS_PER_PERIOD, default 50000000, meaning clocks between telemetry ticks (legal range 2 to 2^26-1).
REQ-002 The block SHALL have port clk  input  1  system clock, rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port enable  input  1  gates the periodic telemetry timer.
REQ-005 The block SHALL have port moisture, temperature, light, ai_decision  input  8 each  telemetry payload sources.
REQ-006 The block SHALL have port alert_req  input  1  level request for an alert frame, held until acknowledged.
REQ-007 The block SHALL have port alert_code  input  8  alert payload, valid while alert_req is high.
REQ-008 The block SHALL have port alert_ack  output  1  one-cycle pulse when the alert is accepted.
REQ-009 The block SHALL have port tx_data  output  8  byte to the UART transmitter.
REQ-010 The block SHALL have port tx_valid  output  1  byte valid.
REQ-011 The block SHALL have port tx_ready  input  1  transmitter idle; a byte transfers on a clock edge where tx_valid=1 and tx_ready=1.
REQ-012 The block SHALL have port busy  output  1  high from LOAD until the last byte transfers.
REQ-013 The block SHALL have port frame_seq  output  8  count of completed frames, wraps 0xFF->0x00.

Function
REQ-014 Frame format SHALL be fixed at 7 bytes: SOF=0xA5, TYPE, P0, P1, P2, P3, CHK, with CHK = XOR of TYPE, P0, P1, P2 and P3.
REQ-015 Telemetry frame SHALL have TYPE=0x01 and P0..P3 = moisture, temperature, light, ai_decision.
REQ-016 Alert frame SHALL have TYPE=0x02, P0=alert_code, P1=frame_seq, P2=0x00, P3=0x00.
REQ-017 Period timer: with enable=1 it SHALL count 0..CLKS_PER_PERIOD-1 and set tele_pending on the wrap cycle; with enable=0 it SHALL hold at 0.
REQ-018 A tick arriving while tele_pending is already set SHALL coalesce, producing no second frame.
REQ-019 Deasserting enable SHALL NOT clear an already-set tele_pending.
REQ-020 FSM states SHALL be IDLE, LOAD, SEND.
REQ-021 IDLE -> LOAD SHALL occur when alert_req=1 or tele_pending=1.
REQ-022 In LOAD, alert_req SHALL take priority over tele_pending.
REQ-023 LOAD SHALL last exactly 1 cycle: snapshot all 7 bytes into a frame register, pulse alert_ack if an alert was chosen, and clear tele_pending if telemetry was chosen.
REQ-024 In SEND, tx_valid SHALL be 1 and tx_data SHALL be frame byte[idx], with idx starting at 0; a transfer advances idx on the same edge.
REQ-025 A transfer with idx=6 SHALL return the FSM to IDLE, deassert tx_valid, and increment frame_seq.
REQ-026 Between transfers, tx_valid SHALL stay high and tx_data SHALL stay stable.
REQ-027 A frame SHALL never be preempted; requests arriving mid-frame SHALL be served after it, alert first.
REQ-028 Input changes after LOAD SHALL NOT affect the frame in flight.
REQ-029 Timing SHALL be: request seen in IDLE at edge N, then LOAD during cycle N+1 and first tx_valid=1 during cycle N+2.
REQ-030 Back-to-back frames SHALL pass through IDLE and LOAD, a minimum of 2 cycles between the last transfer and the next tx_valid.
REQ-031 When alert_req and a tick coincide, the alert frame SHALL be sent first and the telemetry frame immediately after.

Reset
REQ-032 On rst_n=0 the block SHALL reset asynchronously to: FSM=IDLE, idx=0, timer=0, tele_pending=0, tx_valid=0, tx_data=0x00, alert_ack=0, busy=0, frame_seq=0x00, frame register=0.
REQ-033 Reset mid-frame SHALL abandon the frame with no resumption; the downstream transmitter shares rst_n.

Structure
REQ-034 Package uart_frame_pkg SHALL hold SOF, the TYPE codes, FRAME_LEN=7, and the FSM state encoding.
REQ-035 Sub-module frame_period_timer (parameter CLKS_PER_PERIOD; ports enable, tick) SHALL implement the period counter.
REQ-036 The byte mux and checksum SHALL be inline in uart_frame_scheduler.

Verification
REQ-037 The bench SHALL use CLKS_PER_PERIOD=2000 and a uart_tx with CLKS_PER_BIT=4 as the tx_ready/tx_valid partner.
REQ-038 Telemetry: enable=1 with inputs 0x12, 0x34, 0x56, 0x78 -> decoded line bytes A5 01 12 34 56 78 09, then frame_seq=1.
REQ-039 Alert: after 3 frames, alert_req=1 and alert_code=0x5A -> alert_ack pulse 1 cycle after the request is seen, then bytes A5 02 5A 03 00 00 5B.
REQ-040 Collision: alert_req and tick in the same cycle -> alert frame then telemetry frame, with no idle period between them beyond 2 cycles.
REQ-041 Coalescing: hold tx_ready=0 for 5000 cycles -> exactly one telemetry frame after release, with tx_data stable throughout the stall.
REQ-042 Reset at the 3rd byte -> all outputs at reset values within the reset cycle, and a clean full frame after the next tick.
